wide_add_ctrl: RTL and testbench

WIDE_ADD_CTRL -- requirements
Module: wide_add_ctrl

---
 rtl/wide_add_ctrl.sv | 171 +++++++++++++++++
 tb/tb_wide_add_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wide_add_ctrl.sv
// -----------------------------------------------------------------------------
// wide_add_ctrl
//
// Purpose:
//   Adds two operands of WORDS x 32 bits, plus a carry-in. It uses one external
//   32-bit combinational adder and feeds it one word per cycle, starting with
//   the least significant word. The carry between words is held in a register.
//   A request is accepted in IDLE. The controller then spends exactly WORDS
//   cycles in RUN, one word per cycle. The result is held in DONE until the
//   consumer takes it.
//
// Ports:
//   clk        in   1        single clock, rising edge
//   rst        in   1        synchronous, active-high reset
//   in_valid   in   1        request holds valid operands
//   in_ready   out  1        request accepted this cycle (high only in IDLE)
//   a, b       in   W        operands, W = 32*WORDS
//   ci         in   1        carry-in
//   out_valid  out  1        s/co hold a result (high only in DONE)
//   out_ready  in   1        consumer takes the result
//   s          out  W        sum
//   co         out  1        carry-out
//   add_a      out  32       A word to the external adder (0 outside RUN)
//   add_b      out  32       B word to the external adder (0 outside RUN)
//   add_ci     out  1        carry-in to the external adder (0 outside RUN)
//   add_s      in   32       sum from the external adder (combinational)
//   add_co     in   1        carry-out from the external adder
// -----------------------------------------------------------------------------
module wide_add_ctrl #(
    parameter int WORDS = 4            // legal 2..8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [32*WORDS-1:0]   a,
    input  logic [32*WORDS-1:0]   b,
    input  logic                  ci,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [32*WORDS-1:0]   s,
    output logic                  co,
    output logic [31:0]           add_a,
    output logic [31:0]           add_b,
    output logic                  add_ci,
    input  logic [31:0]           add_s,
    input  logic                  add_co
);

    localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Operands and sum are stored as arrays of 32-bit words. This makes
    // "word k" a plain index instead of a computed part-select.
    typedef logic [WORDS-1:0][31:0] words_t;

    state_t         state_q, state_d;
    logic [KW-1:0]  k_q,     k_d;
    logic           carry_q, carry_d;   // carry out of word k-1
    logic           ci_q,    ci_d;      // latched request carry-in
    words_t         a_q,     a_d;
    words_t         b_q,     b_d;
    words_t         s_q,     s_d;
    logic           co_q,    co_d;

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned in this block gets a default first.
        // Without a default, a signal that some branch does not assign keeps
        // its old value, and synthesis builds a latch to hold it.
        state_d   = state_q;
        k_d       = k_q;
        carry_d   = carry_q;
        ci_d      = ci_q;
        a_d       = a_q;
        b_d       = b_q;
        s_d       = s_q;
        co_d      = co_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        add_a     = '0;
        add_b     = '0;
        add_ci    = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    ci_d    = ci;
                    k_d     = '0;
                    state_d = RUN;
                end
            end

            RUN: begin
                add_a  = a_q[k_q];
                add_b  = b_q[k_q];
                // Word 0 takes the request carry-in. Every later word takes
                // the carry registered from the word before it.
                add_ci = (k_q == '0) ? ci_q : carry_q;

                s_d[k_q] = add_s;
                carry_d  = add_co;

                if (k_q == K_LAST) begin
                    co_d    = add_co;
                    k_d     = '0;
                    state_d = DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end

            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // The reset clears the operand and sum registers as well as the control
    // state. After a reset, s and co read back as zero, and no operand left
    // over from the aborted request is still visible.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) assignments only.
        // All registers then update together at the clock edge, and no
        // register depends on the order of the assignments in this block.
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            carry_q <= 1'b0;
            ci_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            co_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            carry_q <= carry_d;
            ci_q    <= ci_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            co_q    <= co_d;
        end
    end

    assign s  = s_q;
    assign co = co_q;

endmodule

// File: tb/tb_wide_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wide_add_ctrl
//
// Directed bench for wide_add_ctrl with WORDS = 4. The bench models the
// external 32-bit adder. Inputs are driven, and outputs sampled, on the falling
// edge. The expected {co, s} of every accepted request goes into a scoreboard
// queue, and is popped when out_valid rises.
// -----------------------------------------------------------------------------
module tb_wide_add_ctrl;

    localparam int WORDS = 4;
    localparam int W     = 32 * WORDS;

    typedef logic [W:0] val_t;   // {co, s}

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          ci;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  s;
    logic          co;
    logic [31:0]   add_a;
    logic [31:0]   add_b;
    logic          add_ci;
    logic [31:0]   add_s;
    logic          add_co;

    val_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    wide_add_ctrl #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .co        (co),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_ci    (add_ci),
        .add_s     (add_s),
        .add_co    (add_co)
    );

    // External 32-bit combinational adder.
    assign {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_ci};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input val_t obs, input val_t exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd();
        logic [W-1:0] v;
        for (int i = 0; i < WORDS; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    function automatic val_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic civ);
        return {1'b0, av} + {1'b0, bv} + val_t'(civ);
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    // Must be called in IDLE, at a falling edge. On return, the bench is at the
    // falling edge right after the accepting rising edge (RUN, k = 0).
    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic civ, input val_t expv);
        check("in_ready_idle", val_t'(in_ready), val_t'(1));
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        ci       = civ;
        exp_q.push_back(expv);
        tick();
        in_valid = 1'b0;
        a        = rnd();
        b        = rnd();
        ci       = 1'($urandom_range(0, 1));
    endtask

    // Waits for out_valid, holds out_ready low for 'hold' cycles, then
    // releases it. While the controller is busy, garbage operands are driven
    // with in_valid high; the controller must ignore them.
    task automatic wait_result(input int hold);
        int   lat  = -1;
        bit   seen = 1'b0;
        val_t got;
        val_t expv;
        out_ready = 1'b0;
        for (int i = 1; i <= 3 * WORDS && !seen; i++) begin
            if (out_valid) begin
                seen = 1'b1;
                lat  = i;
            end else begin
                check("in_ready_busy", val_t'(in_ready), val_t'(0));
                in_valid = 1'b1;
                a        = rnd();
                b        = rnd();
                ci       = 1'($urandom_range(0, 1));
                tick();
            end
        end
        in_valid = 1'b0;
        check("latency", val_t'(lat), val_t'(WORDS + 1));
        if (seen) begin
            got = {co, s};
            check("sb_nonempty", val_t'(exp_q.size() != 0), val_t'(1));
            if (exp_q.size() != 0) begin
                expv = exp_q.pop_front();
                check("result", got, expv);
            end
            for (int i = 0; i < hold; i++) begin
                tick();
                check("hold_valid",    val_t'(out_valid), val_t'(1));
                check("hold_result",   {co, s},           got);
                check("hold_in_ready", val_t'(in_ready),  val_t'(0));
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            check("exit_valid", val_t'(out_valid), val_t'(0));
            check("exit_ready", val_t'(in_ready),  val_t'(1));
            check("retain",     {co, s},           got);
        end else if (exp_q.size() != 0) begin
            void'(exp_q.pop_front());
        end
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           n_acc;
        int           n_out;
        bit           stray;

        // Reset, with in_valid high: the request must not be taken.
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        a         = rnd();
        b         = rnd();
        ci        = 1'b1;
        tick();
        tick();
        check("rst_in_ready",  val_t'(in_ready),  val_t'(1));
        check("rst_out_valid", val_t'(out_valid), val_t'(0));
        check("rst_sum",       {co, s},           val_t'(0));
        check("rst_add_a",     val_t'(add_a),     val_t'(0));
        check("rst_add_ci",    val_t'(add_ci),    val_t'(0));
        rst      = 1'b0;
        in_valid = 1'b0;
        tick();
        check("idle_in_ready", val_t'(in_ready), val_t'(1));

        // 0x77777777 words + all ones, ci=0.
        send({4{32'h7777_7777}}, {4{32'hFFFF_FFFF}}, 1'b0,
             {1'b1, 128'h77777777_77777777_77777777_77777776});
        check("run_add_a_k0", val_t'(add_a), val_t'(32'h7777_7777));
        wait_result(0);

        // Alternating patterns: no carry with ci=0, a full ripple with ci=1.
        send({4{32'hAAAA_AAAA}}, {4{32'h5555_5555}}, 1'b0,
             {1'b0, {4{32'hFFFF_FFFF}}});
        wait_result(0);
        send({4{32'hAAAA_AAAA}}, {4{32'h5555_5555}}, 1'b1,
             {1'b1, 128'h0});
        wait_result(0);

        // 0xCCCCCCCC doubled, then all zero. The first result is held for
        // 10 cycles against back-pressure.
        send({4{32'hCCCC_CCCC}}, {4{32'hCCCC_CCCC}}, 1'b0,
             {1'b1, 128'h99999999_99999999_99999999_99999998});
        wait_result(10);
        send('0, '0, 1'b0, val_t'(0));
        wait_result(0);

        // A synchronous reset in RUN, cycle k=2, aborts the request.
        ra = rnd();
        rb = rnd();
        send(ra, rb, 1'b1, model(ra, rb, 1'b1));
        tick();
        tick();
        check("run_add_a_k2", val_t'(add_a), val_t'(ra[95:64]));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        check("abort_in_ready",  val_t'(in_ready),  val_t'(1));
        check("abort_out_valid", val_t'(out_valid), val_t'(0));
        check("abort_sum",       {co, s},           val_t'(0));
        check("abort_add_a",     val_t'(add_a),     val_t'(0));
        stray = 1'b0;
        for (int i = 0; i < 2 * WORDS; i++) begin
            tick();
            if (out_valid) stray = 1'b1;
        end
        check("abort_no_valid", val_t'(stray), val_t'(0));

        // A fresh request after the abort.
        ra = rnd();
        rb = rnd();
        send(ra, rb, 1'b0, model(ra, rb, 1'b0));
        wait_result(0);

        // in_valid held high, with new operands every cycle. Only IDLE cycles
        // accept, and each accepted request yields exactly one out_valid cycle.
        n_acc     = 0;
        n_out     = 0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (out_valid) begin
                n_out++;
                check("stream_sb_nonempty", val_t'(exp_q.size() != 0), val_t'(1));
                if (exp_q.size() != 0) check("stream_result", {co, s}, exp_q.pop_front());
            end
            ra       = rnd();
            rb       = rnd();
            in_valid = 1'b1;
            a        = ra;
            b        = rb;
            ci       = 1'($urandom_range(0, 1));
            if (in_ready) begin
                exp_q.push_back(model(ra, rb, ci));
                n_acc++;
            end
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3 * WORDS; i++) begin
            if (out_valid) begin
                n_out++;
                check("stream_sb_nonempty", val_t'(exp_q.size() != 0), val_t'(1));
                if (exp_q.size() != 0) check("stream_result", {co, s}, exp_q.pop_front());
            end
            tick();
        end
        out_ready = 1'b0;
        // With WORDS = 4 and out_ready held high, one request takes 6 cycles.
        check("stream_accepts",  val_t'(n_acc),        val_t'(7));
        check("stream_outputs",  val_t'(n_out),        val_t'(n_acc));
        check("stream_sb_empty", val_t'(exp_q.size()), val_t'(0));
        check("final_idle",      val_t'(in_ready),     val_t'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
